punc_datapath: RTL and testbench

Datapath for the PUnC LC3 processor, and the responder end of the PUnC control interface. Each cycle it executes the control unit's strobes and selects. It holds PC, IR, the 8x16 register file, the NZP status flags and the indirect-address register. It returns ir, n, z and p to the control unit and drives a 16-bit memory port that has combinational read and synchronous write.

---
 rtl/punc_datapath_pkg.sv | 60 ++++++
 rtl/punc_regfile.sv | 36 +++
 rtl/punc_datapath.sv | 128 ++++++++++++
 tb/tb_punc_datapath.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_datapath_pkg.sv
// Shared encodings and instruction-field helpers for the PUnC LC3 datapath
// and its control unit.
package punc_datapath_pkg;

    typedef enum logic [1:0] {
        ALU_THRU = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_AND  = 2'd2,
        ALU_NOT  = 2'd3
    } alu_op_e;

    localparam logic [1:0] OP1_PC   = 2'd0;
    localparam logic [1:0] OP1_RF_0 = 2'd1;
    localparam logic [1:0] OP1_RF_1 = 2'd2;

    localparam logic [2:0] OP2_OFF9  = 3'd0;
    localparam logic [2:0] OP2_OFF11 = 3'd1;
    localparam logic [2:0] OP2_OFF6  = 3'd2;
    localparam logic [2:0] OP2_IMM5  = 3'd3;
    localparam logic [2:0] OP2_SR2   = 3'd4;

    localparam logic RF_S_ALU  = 1'b0;
    localparam logic RF_S_MEM  = 1'b1;
    localparam logic MEM_S_ALU = 1'b0;
    localparam logic MEM_S_IND = 1'b1;

    // LC3 opcodes held in ir[15:12]
    localparam logic [3:0] OPC_BR   = 4'b0000;
    localparam logic [3:0] OPC_ADD  = 4'b0001;
    localparam logic [3:0] OPC_LD   = 4'b0010;
    localparam logic [3:0] OPC_ST   = 4'b0011;
    localparam logic [3:0] OPC_JSR  = 4'b0100;
    localparam logic [3:0] OPC_AND  = 4'b0101;
    localparam logic [3:0] OPC_LDR  = 4'b0110;
    localparam logic [3:0] OPC_STR  = 4'b0111;
    localparam logic [3:0] OPC_RTI  = 4'b1000;
    localparam logic [3:0] OPC_NOT  = 4'b1001;
    localparam logic [3:0] OPC_LDI  = 4'b1010;
    localparam logic [3:0] OPC_STI  = 4'b1011;
    localparam logic [3:0] OPC_JMP  = 4'b1100;
    localparam logic [3:0] OPC_LEA  = 4'b1110;
    localparam logic [3:0] OPC_TRAP = 4'b1111;

    function automatic logic [15:0] sext5(input logic [15:0] v);
        return {{11{v[4]}}, v[4:0]};
    endfunction

    function automatic logic [15:0] sext6(input logic [15:0] v);
        return {{10{v[5]}}, v[5:0]};
    endfunction

    function automatic logic [15:0] sext9(input logic [15:0] v);
        return {{7{v[8]}}, v[8:0]};
    endfunction

    function automatic logic [15:0] sext11(input logic [15:0] v);
        return {{5{v[10]}}, v[10:0]};
    endfunction

endpackage

// File: rtl/punc_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write
// port and a debug read port; cleared synchronously on rst.
module punc_regfile
    import punc_datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  raddr0,
    output logic [15:0] rdata0,
    input  logic [2:0]  raddr1,
    output logic [15:0] rdata1,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    logic [15:0] regs [8];

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata0   = regs[raddr0];
    assign rdata1   = regs[raddr1];
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: PC, IR, register file, NZP flags and the indirect
// address register, steered cycle by cycle by the control unit's strobes.
module punc_datapath
    import punc_datapath_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_mem,
    input  logic        jsr_s,
    input  logic [1:0]  alu_s,
    input  logic        write_ir,
    input  logic        write_status,
    input  logic        write_rf,
    input  logic        ld_ldi,
    input  logic        mem_s,
    input  logic        pc_ld,
    input  logic        inc_pc,
    input  logic [1:0]  op1_s,
    input  logic [2:0]  op2_s,
    input  logic        rf_s,
    input  logic        rf_raddr0_s,
    input  logic        rf_raddr1_s,
    output logic [15:0] ir,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    input  logic [2:0]  dbg_rf_addr,
    output logic [15:0] dbg_rf_data
);

    logic [2:0]  raddr0, raddr1, waddr;
    logic [15:0] rdata0, rdata1;
    logic [15:0] op_a, op_b, alu_y, rf_wdata;
    logic [15:0] ind_q;
    logic        unused_ld_ldi;

    assign unused_ld_ldi = ld_ldi;

    assign raddr0   = rf_raddr0_s ? ir[11:9] : ir[8:6];
    assign raddr1   = rf_raddr1_s ? ir[8:6]  : ir[2:0];
    assign waddr    = jsr_s ? 3'd7 : ir[11:9];
    assign rf_wdata = (rf_s == RF_S_MEM) ? mem_rdata : alu_y;

    punc_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr0   (raddr0),
        .rdata0   (rdata0),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .we       (write_rf),
        .waddr    (waddr),
        .wdata    (rf_wdata),
        .dbg_addr (dbg_rf_addr),
        .dbg_data (dbg_rf_data)
    );

    always_comb begin
        op_a = pc;
        case (op1_s)
            OP1_RF_0: op_a = rdata0;
            OP1_RF_1: op_a = rdata1;
            default:  op_a = pc;
        endcase
    end

    // Unused op2 codes fall back to OFF9, the PC-relative default.
    always_comb begin
        op_b = sext9(ir);
        case (op2_s)
            OP2_OFF11: op_b = sext11(ir);
            OP2_OFF6:  op_b = sext6(ir);
            OP2_IMM5:  op_b = sext5(ir);
            OP2_SR2:   op_b = rdata1;
            default:   op_b = sext9(ir);
        endcase
    end

    always_comb begin
        alu_y = op_a;
        case (alu_op_e'(alu_s))
            ALU_THRU: alu_y = op_a;
            ALU_ADD:  alu_y = op_a + op_b;
            ALU_AND:  alu_y = op_a & op_b;
            ALU_NOT:  alu_y = ~op_a;
            default:  alu_y = op_a;
        endcase
    end

    assign mem_addr  = (mem_s == MEM_S_IND) ? ind_q : alu_y;
    assign mem_wdata = rdata0;
    assign mem_we    = write_mem;

    // ind_q samples memory every cycle so LDI/STI can chase the pointer next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= PC_RESET;
            ir    <= '0;
            n     <= 1'b0;
            z     <= 1'b1;
            p     <= 1'b0;
            ind_q <= '0;
        end else begin
            if (pc_ld) begin
                pc <= alu_y;
            end else if (inc_pc) begin
                pc <= pc + 16'd1;
            end
            if (write_ir) begin
                ir <= mem_rdata;
            end
            if (write_status) begin
                n <= rf_wdata[15];
                z <= (rf_wdata == 16'h0000);
                p <= !rf_wdata[15] && (rf_wdata != 16'h0000);
            end
            ind_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_punc_datapath.sv
// Bench for punc_datapath: directed LC3 instruction sequences followed by
// randomized strobes, checked against an arithmetic model of the datapath.
module tb_punc_datapath;
    import punc_datapath_pkg::*;

    typedef struct packed {
        logic       write_mem;
        logic       jsr_s;
        logic [1:0] alu_s;
        logic       write_ir;
        logic       write_status;
        logic       write_rf;
        logic       ld_ldi;
        logic       mem_s;
        logic       pc_ld;
        logic       inc_pc;
        logic [1:0] op1_s;
        logic [2:0] op2_s;
        logic       rf_s;
        logic       rf_raddr0_s;
        logic       rf_raddr1_s;
    } ctl_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctl_t        c;
    logic [15:0] ir, mem_addr, mem_wdata, mem_rdata, pc, dbg_rf_data;
    logic        n, z, p, mem_we;
    logic [2:0]  dbg_rf_addr;

    punc_datapath #(.PC_RESET(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_mem    (c.write_mem),
        .jsr_s        (c.jsr_s),
        .alu_s        (c.alu_s),
        .write_ir     (c.write_ir),
        .write_status (c.write_status),
        .write_rf     (c.write_rf),
        .ld_ldi       (c.ld_ldi),
        .mem_s        (c.mem_s),
        .pc_ld        (c.pc_ld),
        .inc_pc       (c.inc_pc),
        .op1_s        (c.op1_s),
        .op2_s        (c.op2_s),
        .rf_s         (c.rf_s),
        .rf_raddr0_s  (c.rf_raddr0_s),
        .rf_raddr1_s  (c.rf_raddr1_s),
        .ir           (ir),
        .n            (n),
        .z            (z),
        .p            (p),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .dbg_rf_addr  (dbg_rf_addr),
        .dbg_rf_data  (dbg_rf_data)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    // reference model state
    logic [15:0] m_pc, m_ir, m_ind;
    logic [15:0] m_rf [8];
    logic        m_n, m_z, m_p;

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        int val;
        val = int'(v) % (1 << bits);
        if (val >= (1 << (bits - 1))) val = val - (1 << bits);
        return 16'(val);
    endfunction

    function automatic logic [15:0] m_port0();
        return c.rf_raddr0_s ? m_rf[m_ir[11:9]] : m_rf[m_ir[8:6]];
    endfunction

    function automatic logic [15:0] m_port1();
        return c.rf_raddr1_s ? m_rf[m_ir[8:6]] : m_rf[m_ir[2:0]];
    endfunction

    function automatic logic [15:0] m_alu();
        logic [15:0] a, b;
        if (c.op1_s == 2'd1)      a = m_port0();
        else if (c.op1_s == 2'd2) a = m_port1();
        else                      a = m_pc;
        if (c.op2_s == 3'd1)      b = sx(m_ir, 11);
        else if (c.op2_s == 3'd2) b = sx(m_ir, 6);
        else if (c.op2_s == 3'd3) b = sx(m_ir, 5);
        else if (c.op2_s == 3'd4) b = m_port1();
        else                      b = sx(m_ir, 9);
        if (c.alu_s == 2'd1)      return 16'((int'(a) + int'(b)) % 65536);
        else if (c.alu_s == 2'd2) return a & b;
        else if (c.alu_s == 2'd3) return 16'(65535 - int'(a));
        return a;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 16'h0000; m_ind = 16'h0000;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_n = 1'b0; m_z = 1'b1; m_p = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] y, wd;
        if (rst) begin
            model_reset();
            return;
        end
        y  = m_alu();
        wd = c.rf_s ? mem_rdata : y;
        if (c.write_status) begin
            m_n = (wd >= 16'h8000);
            m_z = (wd == 16'h0000);
            m_p = !m_n && !m_z;
        end
        if (c.pc_ld)       m_pc = y;
        else if (c.inc_pc) m_pc = 16'((int'(m_pc) + 1) % 65536);
        if (c.write_rf) m_rf[c.jsr_s ? 3'd7 : m_ir[11:9]] = wd;
        if (c.write_ir) m_ir = mem_rdata;
        m_ind = mem_rdata;
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic apply(input ctl_t nc, input logic [15:0] rd, input logic r);
        @(negedge clk);
        c = nc;
        mem_rdata = rd;
        rst = r;
        dbg_rf_addr = 3'($urandom_range(0, 7));
        #1;
        check16("mem_addr", mem_addr, c.mem_s ? m_ind : m_alu());
        check16("mem_wdata", mem_wdata, m_port0());
        check16("mem_we", {15'b0, mem_we}, {15'b0, c.write_mem});
        check16("dbg_rf", dbg_rf_data, m_rf[dbg_rf_addr]);
    endtask

    task automatic clock();
        model_edge();
        exp_q.push_back(m_pc);
        exp_q.push_back(m_ir);
        exp_q.push_back({13'b0, m_n, m_z, m_p});
        @(posedge clk);
        #1;
        check16("pc", pc, exp_q.pop_front());
        check16("ir", ir, exp_q.pop_front());
        check16("nzp", {13'b0, n, z, p}, exp_q.pop_front());
    endtask

    task automatic check_reg(input string tag, input logic [2:0] r, input logic [15:0] exp);
        dbg_rf_addr = r;
        #1;
        check16(tag, dbg_rf_data, exp);
    endtask

    task automatic set_ir(input logic [15:0] v);
        ctl_t k;
        k = '0; k.write_ir = 1'b1;
        apply(k, v, 1'b0);
        clock();
    endtask

    task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
        ctl_t k;
        set_ir({4'b0, r, 9'b0});
        k = '0; k.write_rf = 1'b1; k.rf_s = RF_S_MEM;
        apply(k, v, 1'b0);
        clock();
    endtask

    // Goes through R7 and an ALU pass-through, so it clobbers R7 and IR.
    task automatic set_pc(input logic [15:0] v);
        ctl_t k;
        load_reg(3'd7, v);
        set_ir(16'h01C0);
        k = '0; k.pc_ld = 1'b1; k.op1_s = OP1_RF_0; k.alu_s = ALU_THRU;
        apply(k, 16'h0000, 1'b0);
        clock();
    endtask

    initial begin
        ctl_t k;
        logic [31:0] r32;

        c = '0; rst = 1'b1; mem_rdata = 16'h0000; dbg_rf_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state
        check16("rst_pc", pc, 16'h0000);
        check16("rst_ir", ir, 16'h0000);
        check16("rst_nzp", {13'b0, n, z, p}, 16'h0002);
        for (int i = 0; i < 8; i++) check_reg("rst_rf", 3'(i), 16'h0000);

        // fetch, increment, ADD R1,R1,#1
        set_ir(16'h1261);
        check16("fetch_ir", ir, 16'h1261);
        k = '0; k.inc_pc = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check16("inc_pc", pc, 16'h0001);
        k = '0; k.op1_s = OP1_RF_0; k.op2_s = OP2_IMM5; k.alu_s = ALU_ADD;
        k.write_rf = 1'b1; k.write_status = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check_reg("addimm_r1", 3'd1, 16'h0001);
        check16("addimm_nzp", {13'b0, n, z, p}, 16'h0001);

        // NOT R2,R1
        set_ir(16'h947F);
        k = '0; k.op1_s = OP1_RF_0; k.alu_s = ALU_NOT; k.write_rf = 1'b1; k.write_status = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check_reg("not_r2", 3'd2, 16'hFFFE);
        check16("not_nzp", {13'b0, n, z, p}, 16'h0004);

        // LDI R2, pc-2
        set_pc(16'h0010);
        set_ir(16'hA5FE);
        k = '0; k.op1_s = OP1_PC; k.op2_s = OP2_OFF9; k.alu_s = ALU_ADD;
        apply(k, 16'h0040, 1'b0);
        check16("ldi_addr1", mem_addr, 16'h000E);
        clock();
        k = '0; k.mem_s = MEM_S_IND; k.rf_s = RF_S_MEM; k.write_rf = 1'b1; k.write_status = 1'b1;
        apply(k, 16'h8000, 1'b0);
        check16("ldi_addr2", mem_addr, 16'h0040);
        clock();
        check_reg("ldi_r2", 3'd2, 16'h8000);
        check16("ldi_nzp", {13'b0, n, z, p}, 16'h0004);

        // STR R3, R4, #-1
        load_reg(3'd3, 16'h1234);
        load_reg(3'd4, 16'h0100);
        set_ir(16'h773F);
        k = '0; k.write_mem = 1'b1; k.op1_s = OP1_RF_1; k.rf_raddr1_s = 1'b1;
        k.rf_raddr0_s = 1'b1; k.op2_s = OP2_OFF6; k.alu_s = ALU_ADD;
        apply(k, 16'h0000, 1'b0);
        check16("str_addr", mem_addr, 16'h00FF);
        check16("str_wdata", mem_wdata, 16'h1234);
        check16("str_we", {15'b0, mem_we}, 16'h0001);
        clock();
        check16("str_nzp", {13'b0, n, z, p}, 16'h0004);

        // JSRR R4, then BR back by 3
        set_pc(16'h0020);
        set_ir(16'h4100);
        k = '0; k.jsr_s = 1'b1; k.write_rf = 1'b1; k.op1_s = OP1_PC; k.alu_s = ALU_THRU;
        apply(k, 16'h0000, 1'b0); clock();
        check_reg("jsr_r7", 3'd7, 16'h0020);
        check16("jsr_nzp", {13'b0, n, z, p}, 16'h0004);
        k = '0; k.pc_ld = 1'b1; k.op1_s = OP1_RF_0; k.alu_s = ALU_THRU;
        apply(k, 16'h0000, 1'b0); clock();
        check16("jsrr_pc", pc, 16'h0100);
        k = '0; k.inc_pc = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check16("jsrr_inc", pc, 16'h0101);
        set_ir(16'h0FFD);
        k = '0; k.pc_ld = 1'b1; k.op1_s = OP1_PC; k.op2_s = OP2_OFF9; k.alu_s = ALU_ADD;
        apply(k, 16'h0000, 1'b0); clock();
        check16("br_pc", pc, 16'h00FE);
        k.inc_pc = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check16("pcld_prio", pc, 16'h00FB);

        // PC wrap and reset mid-instruction
        set_pc(16'hFFFF);
        k = '0; k.inc_pc = 1'b1;
        apply(k, 16'h0000, 1'b0); clock();
        check16("pc_wrap", pc, 16'h0000);
        k = '1;
        apply(k, 16'hBEEF, 1'b1); clock();
        check16("midrst_pc", pc, 16'h0000);
        check16("midrst_ir", ir, 16'h0000);
        check16("midrst_nzp", {13'b0, n, z, p}, 16'h0002);
        check_reg("midrst_r7", 3'd7, 16'h0000);

        // randomized strobes against the model
        for (int i = 0; i < 400; i++) begin
            r32 = $urandom;
            k = r32[$bits(ctl_t)-1:0];
            apply(k, 16'($urandom), ($urandom_range(0, 49) == 0));
            clock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
